// File: rtl/rs_codec_pkg.sv
// Shared types and sizes for the RS(15,9) codec scheduler.
// Symbol geometry, FSM state and grant encodings, result widening helper.
package rs_codec_pkg;

  localparam int RS_N  = 15;
  localparam int RS_K  = 9;
  localparam int SYM_W = 4;
  localparam int MSG_W = RS_K * SYM_W;
  localparam int CW_W  = RS_N * SYM_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  typedef enum logic {
    GNT_ENC = 1'b0,
    GNT_DEC = 1'b1
  } gnt_t;

  function automatic logic [CW_W-1:0] msg_to_cw(
    input logic [MSG_W-1:0] m
  );
    return {{(CW_W-MSG_W){1'b0}}, m};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: req[0]=encode, req[1]=decode.
// Ports: req (eligible requesters), last_grant (previous winner), gnt (one-hot).
module rr_arbiter2
  import rs_codec_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_t       last_grant,
  output logic [1:0] gnt
);

  // On a tie the side that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last_grant == GNT_DEC) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/rs_codec_scheduler.sv
// Shares one RS(15,9) encoder and one decoder between two requesters.
// Ports: enc/dec request handshakes, engine operand/start/busy/result
// buses, and a single valid/ready result port (res_*).
module rs_codec_scheduler
  import rs_codec_pkg::*;
#(
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_req_valid,
  output logic             enc_req_ready,
  input  logic [MSG_W-1:0] enc_req_msg,
  input  logic             dec_req_valid,
  output logic             dec_req_ready,
  input  logic [CW_W-1:0]  dec_req_word,
  output logic [MSG_W-1:0] enc_msg,
  output logic             enc_start,
  input  logic             enc_busy,
  input  logic [CW_W-1:0]  enc_codeword,
  output logic [CW_W-1:0]  dec_word,
  output logic             dec_start,
  input  logic             dec_busy,
  input  logic [MSG_W-1:0] dec_message,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_is_dec,
  output logic             res_err,
  output logic [CW_W-1:0]  res_data
);

  state_t     state;
  gnt_t       last_grant;
  gnt_t       cur;
  logic [7:0] cnt;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       idle;
  logic       busy_sel;
  logic       min_ok;

  // A requester whose engine is still busy is not eligible.
  assign req = {dec_req_valid & ~dec_busy,
                enc_req_valid & ~enc_busy};

  rr_arbiter2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Readies are forced low while reset is asserted.
  assign idle = rst_n & (state == ST_IDLE);
  assign enc_req_ready = idle & gnt[0];
  assign dec_req_ready = idle & gnt[1];

  assign busy_sel = (cur == GNT_DEC) ? dec_busy : enc_busy;
  // Busy is not trusted until the engine has had time to raise it.
  assign min_ok = (cnt >= 8'(MIN_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= GNT_DEC;
      cur        <= GNT_ENC;
      cnt        <= '0;
      enc_msg    <= '0;
      dec_word   <= '0;
      enc_start  <= 1'b0;
      dec_start  <= 1'b0;
      res_valid  <= 1'b0;
      res_is_dec <= 1'b0;
      res_err    <= 1'b0;
      res_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          unique case (1'b1)
            gnt[0]: begin
              enc_msg    <= enc_req_msg;
              cur        <= GNT_ENC;
              last_grant <= GNT_ENC;
              state      <= ST_ISSUE;
            end
            gnt[1]: begin
              dec_word   <= dec_req_word;
              cur        <= GNT_DEC;
              last_grant <= GNT_DEC;
              state      <= ST_ISSUE;
            end
            default: ;
          endcase
        end
        ST_ISSUE: begin
          if (cur == GNT_DEC) begin
            dec_start <= ~dec_start;
          end else begin
            enc_start <= ~enc_start;
          end
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 8'd1;
          if (min_ok && !busy_sel) begin
            res_data   <= (cur == GNT_DEC) ?
                          msg_to_cw(dec_message) :
                          enc_codeword;
            res_is_dec <= (cur == GNT_DEC);
            res_err    <= 1'b0;
            res_valid  <= 1'b1;
            state      <= ST_HOLD;
          end else if (cnt == 8'(TIMEOUT)) begin
            res_data   <= '0;
            res_is_dec <= (cur == GNT_DEC);
            res_err    <= 1'b1;
            res_valid  <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_codec_scheduler.sv
// Bench for rs_codec_scheduler with busy-N engine stubs.
// Job-level reference model plus directed literal checks.
module tb_rs_codec_scheduler;
  import rs_codec_pkg::*;

  localparam int MIN_WAIT = 2;
  localparam int TIMEOUT  = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enc_req_valid;
  logic             enc_req_ready;
  logic [MSG_W-1:0] enc_req_msg;
  logic             dec_req_valid;
  logic             dec_req_ready;
  logic [CW_W-1:0]  dec_req_word;
  logic [MSG_W-1:0] enc_msg;
  logic             enc_start;
  logic             enc_busy;
  logic [CW_W-1:0]  enc_codeword;
  logic [CW_W-1:0]  dec_word;
  logic             dec_start;
  logic             dec_busy;
  logic [MSG_W-1:0] dec_message;
  logic             res_valid;
  logic             res_ready;
  logic             res_is_dec;
  logic             res_err;
  logic [CW_W-1:0]  res_data;

  rs_codec_scheduler #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enc_req_valid (enc_req_valid),
    .enc_req_ready (enc_req_ready),
    .enc_req_msg   (enc_req_msg),
    .dec_req_valid (dec_req_valid),
    .dec_req_ready (dec_req_ready),
    .dec_req_word  (dec_req_word),
    .enc_msg       (enc_msg),
    .enc_start     (enc_start),
    .enc_busy      (enc_busy),
    .enc_codeword  (enc_codeword),
    .dec_word      (dec_word),
    .dec_start     (dec_start),
    .dec_busy      (dec_busy),
    .dec_message   (dec_message),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_is_dec    (res_is_dec),
    .res_err       (res_err),
    .res_data      (res_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Stub engine results.
  logic [7:0]       enc_n = 8'd0;
  logic [7:0]       dec_n = 8'd0;
  bit               dec_stuck = 1'b0;
  bit               dec_ovr_en = 1'b0;
  logic [MSG_W-1:0] dec_ovr = '0;

  function automatic logic [CW_W-1:0] enc_ref(input logic [MSG_W-1:0] m);
    return {m[23:0] ^ 24'h5A5A5A, m};
  endfunction

  function automatic logic [MSG_W-1:0] dec_ref(input logic [CW_W-1:0] w);
    if (dec_ovr_en) return dec_ovr;
    return w[35:0] ^ w[59:24];
  endfunction

  assign enc_codeword = enc_ref(enc_msg);
  assign dec_message  = dec_ref(dec_word);

  // Engines: busy for N cycles starting the cycle the toggle is seen.
  logic       e_prev, d_prev, d_stk;
  logic [7:0] e_bc, d_bc;
  logic       e_tog, d_tog;
  assign e_tog = (enc_start != e_prev);
  assign d_tog = (dec_start != d_prev);
  assign enc_busy = (e_tog && enc_n != 0) || (e_bc != 0);
  assign dec_busy = (d_tog && (dec_n != 0 || dec_stuck)) ||
                    (d_bc != 0) || d_stk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_prev <= 1'b0; d_prev <= 1'b0; d_stk <= 1'b0;
      e_bc <= '0; d_bc <= '0;
    end else begin
      e_prev <= enc_start;
      d_prev <= dec_start;
      if (e_tog && enc_n != 0) e_bc <= enc_n - 8'd1;
      else if (e_bc != 0) e_bc <= e_bc - 8'd1;
      if (d_tog && dec_n != 0) d_bc <= dec_n - 8'd1;
      else if (d_bc != 0) d_bc <= d_bc - 8'd1;
      if (!dec_stuck) d_stk <= 1'b0;
      else if (d_tog) d_stk <= 1'b1;
    end
  end

  // Job-level reference model.
  typedef struct {
    bit              is_dec;
    bit              err;
    logic [CW_W-1:0] data;
    int              acc;
    int              due;
  } job_t;

  job_t             job;
  bit               inflight = 1'b0;
  bit               m_last = 1'b1;
  logic             m_es = 1'b0, m_ds = 1'b0;
  logic [MSG_W-1:0] m_msg = '0;
  logic [CW_W-1:0]  m_word = '0;
  bit               enc_took = 1'b0, dec_took = 1'b0;
  int               enc_rdy_cnt = 0, dec_rdy_cnt = 0;
  int               enc_tog_cnt = 0, dec_tog_cnt = 0;
  logic             p_es = 1'b0, p_ds = 1'b0;
  bit               seen_rise = 1'b0;
  int               last_lat = 0;
  logic [CW_W-1:0]  last_data = '0;
  logic             last_err = 1'b0, last_isd = 1'b0;
  bit               gnt_log[$];
  bit               ee, ed, ev;
  int               n, done;

  always @(negedge clk) begin
    enc_took = 1'b0;
    dec_took = 1'b0;
    if (!rst_n) begin
      inflight = 1'b0; m_last = 1'b1;
      m_es = 1'b0; m_ds = 1'b0;
      m_msg = '0; m_word = '0;
      p_es = 1'b0; p_ds = 1'b0;
    end else begin
      ee = 1'b0; ed = 1'b0;
      if (!inflight) begin
        if (enc_req_valid && !enc_busy && dec_req_valid && !dec_busy) begin
          if (m_last) ee = 1'b1; else ed = 1'b1;
        end else if (enc_req_valid && !enc_busy) ee = 1'b1;
        else if (dec_req_valid && !dec_busy) ed = 1'b1;
      end
      chk("enc_req_ready", 64'(enc_req_ready), 64'(ee));
      chk("dec_req_ready", 64'(dec_req_ready), 64'(ed));
      if (enc_req_ready) enc_rdy_cnt++;
      if (dec_req_ready) dec_rdy_cnt++;
      if (enc_start !== p_es) enc_tog_cnt++;
      if (dec_start !== p_ds) dec_tog_cnt++;
      p_es = enc_start;
      p_ds = dec_start;
      if (inflight && cyc == job.acc + 2) begin
        if (job.is_dec) m_ds = ~m_ds; else m_es = ~m_es;
      end
      chk("enc_start", 64'(enc_start), 64'(m_es));
      chk("dec_start", 64'(dec_start), 64'(m_ds));
      chk("enc_msg", 64'(enc_msg), 64'(m_msg));
      chk("dec_word", 64'(dec_word), 64'(m_word));
      ev = inflight && (cyc >= job.due);
      chk("res_valid", 64'(res_valid), 64'(ev));
      if (ev) begin
        chk("res_is_dec", 64'(res_is_dec), 64'(job.is_dec));
        chk("res_err", 64'(res_err), 64'(job.err));
        chk("res_data", 64'(res_data), 64'(job.data));
        if (res_valid && !seen_rise) begin
          seen_rise = 1'b1;
          last_lat = cyc - job.acc;
        end
        if (res_valid && res_ready) begin
          last_data = res_data;
          last_err = res_err;
          last_isd = res_is_dec;
          inflight = 1'b0;
        end
      end
      if (ee || ed) begin
        job.is_dec = ed;
        job.acc = cyc;
        seen_rise = 1'b0;
        n = ed ? int'(dec_n) : int'(enc_n);
        if (ed && dec_stuck) begin
          done = 1 << 20;
        end else begin
          done = (n == 0) ? 0 : n + 2;
          if (done < MIN_WAIT + 1) done = MIN_WAIT + 1;
        end
        if (done > 2 + TIMEOUT) begin
          job.err = 1'b1;
          job.due = cyc + 3 + TIMEOUT;
          job.data = '0;
        end else begin
          job.err = 1'b0;
          job.due = cyc + done + 1;
          job.data = ed ? msg_to_cw(dec_ref(dec_req_word)) :
                          enc_ref(enc_req_msg);
        end
        if (ed) begin
          m_word = dec_req_word;
          dec_took = 1'b1;
        end else begin
          m_msg = enc_req_msg;
          enc_took = 1'b1;
        end
        m_last = ed;
        inflight = 1'b1;
        gnt_log.push_back(ed);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic drive(input bit d, input logic [CW_W-1:0] v);
    bit ok;
    ok = 1'b0;
    if (d) begin dec_req_word = v; dec_req_valid = 1'b1; end
    else begin enc_req_msg = v[MSG_W-1:0]; enc_req_valid = 1'b1; end
    for (int k = 0; k < 600 && !ok; k++) begin
      @(posedge clk); #1;
      ok = d ? dec_took : enc_took;
    end
    if (d) dec_req_valid = 1'b0; else enc_req_valid = 1'b0;
    chk("accept_seen", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && inflight; k++) begin
      @(posedge clk); #1;
    end
    chk("idle_reached", 64'(inflight), 64'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_enc_rdy"}, 64'(enc_req_ready), 64'd0);
    chk({nm, "_dec_rdy"}, 64'(dec_req_ready), 64'd0);
    chk({nm, "_enc_start"}, 64'(enc_start), 64'd0);
    chk({nm, "_dec_start"}, 64'(dec_start), 64'd0);
    chk({nm, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({nm, "_res_is_dec"}, 64'(res_is_dec), 64'd0);
    chk({nm, "_res_err"}, 64'(res_err), 64'd0);
    chk({nm, "_res_data"}, 64'(res_data), 64'd0);
    chk({nm, "_enc_msg"}, 64'(enc_msg), 64'd0);
    chk({nm, "_dec_word"}, 64'(dec_word), 64'd0);
  endtask

  function automatic logic [CW_W-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CW_W-1:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW_W-1:0] v;
    bit              ok;
    enc_req_valid = 1'b0; dec_req_valid = 1'b0;
    enc_req_msg = '0; dec_req_word = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesters valid continuously: ENC,DEC,ENC,DEC.
    res_ready = 1'b1;
    enc_req_msg = 36'h123456789; dec_req_word = rnd();
    enc_req_valid = 1'b1; dec_req_valid = 1'b1;
    for (int k = 0; k < 200 && gnt_log.size() < 4; k++) begin
      @(posedge clk); #1;
    end
    enc_req_valid = 1'b0; dec_req_valid = 1'b0;
    chk("alt_count", 64'(gnt_log.size()), 64'd4);
    chk("alt_order", 64'({gnt_log[0], gnt_log[1],
                          gnt_log[2], gnt_log[3]}), 64'b0101);
    wait_idle(100);

    // Encode alpha^11*X with busy 3 cycles.
    enc_n = 8'd3;
    enc_rdy_cnt = 0; enc_tog_cnt = 0; dec_tog_cnt = 0;
    drive(1'b0, 60'h0E0);
    wait_idle(100);
    chk("e0_data", 64'(last_data), 64'h5A5ABA0000000E0);
    chk("e0_is_dec", 64'(last_isd), 64'd0);
    chk("e0_err", 64'(last_err), 64'd0);
    chk("e0_latency", 64'(last_lat), 64'd6);
    chk("e0_ready_cycles", 64'(enc_rdy_cnt), 64'd1);
    chk("e0_enc_toggles", 64'(enc_tog_cnt), 64'd1);
    chk("e0_dec_toggles", 64'(dec_tog_cnt), 64'd0);

    // Decode a word with three symbol errors.
    dec_n = 8'd4; dec_ovr_en = 1'b1; dec_ovr = 36'h0E0;
    drive(1'b1, 60'h5A5ABA0000000E0 ^ 60'h000000300500070);
    wait_idle(100);
    chk("d0_data", 64'(last_data), 64'h0E0);
    chk("d0_is_dec", 64'(last_isd), 64'd1);
    chk("d0_latency", 64'(last_lat), 64'd7);
    dec_ovr_en = 1'b0;

    // Result held off for 10 cycles with a decode pending.
    res_ready = 1'b0; enc_n = 8'd1;
    enc_tog_cnt = 0; dec_tog_cnt = 0;
    drive(1'b0, rnd());
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk); #1;
      ok = res_valid;
    end
    chk("stall_valid_seen", 64'(ok), 64'd1);
    dec_rdy_cnt = 0;
    dec_req_word = rnd(); dec_req_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("stall_res_valid", 64'(res_valid), 64'd1);
    chk("stall_dec_ready", 64'(dec_rdy_cnt), 64'd0);
    chk("stall_enc_toggles", 64'(enc_tog_cnt), 64'd1);
    chk("stall_dec_toggles", 64'(dec_tog_cnt), 64'd0);
    res_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk); #1;
      ok = dec_took;
    end
    dec_req_valid = 1'b0;
    chk("stall_dec_granted", 64'(ok), 64'd1);
    wait_idle(100);

    // Decoder busy stuck high: timeout result.
    dec_stuck = 1'b1; dec_n = 8'd2;
    drive(1'b1, rnd());
    wait_idle(400);
    chk("to_latency", 64'(last_lat), 64'd258);
    chk("to_err", 64'(last_err), 64'd1);
    chk("to_data", 64'(last_data), 64'd0);
    chk("to_is_dec", 64'(last_isd), 64'd1);
    dec_rdy_cnt = 0;
    dec_req_word = rnd(); dec_req_valid = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("to_no_grant", 64'(dec_rdy_cnt), 64'd0);
    chk("to_busy", 64'(dec_busy), 64'd1);
    dec_stuck = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk); #1;
      ok = dec_took;
    end
    dec_req_valid = 1'b0;
    chk("to_recover_grant", 64'(ok), 64'd1);
    wait_idle(100);

    // Reset in the middle of WAIT.
    enc_n = 8'd20;
    drive(1'b0, rnd());
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    enc_n = 8'd2;
    v = rnd();
    drive(1'b0, v);
    wait_idle(100);
    chk("post_rst_err", 64'(last_err), 64'd0);
    chk("post_rst_latency", 64'(last_lat), 64'd5);
    chk("post_rst_data", 64'(last_data), 64'(enc_ref(v[MSG_W-1:0])));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!inflight) begin
        enc_n = 8'($urandom_range(0, 6));
        dec_n = 8'($urandom_range(0, 6));
      end
      if (enc_req_valid) begin
        if (enc_took || $urandom_range(0, 7) == 0) enc_req_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        v = rnd();
        enc_req_msg = v[MSG_W-1:0];
        enc_req_valid = 1'b1;
      end
      if (dec_req_valid) begin
        if (dec_took || $urandom_range(0, 7) == 0) dec_req_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        dec_req_word = rnd();
        dec_req_valid = 1'b1;
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    enc_req_valid = 1'b0; dec_req_valid = 1'b0; res_ready = 1'b1;
    wait_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
